// File: rtl/phys_reg_free_list_pkg.sv
// Shared core types for the rename stage slice.
// Holds the physical tag / checkpoint column types and the free-list sizing
// (FL_DEPTH, LOG_FL_DEPTH, fl_ptr_t) used by phys_reg_free_list.
package phys_reg_free_list_pkg;

  localparam int NUM_PHYS_REGS      = 64;
  localparam int NUM_ARCH_REGS      = 32;
  localparam int PHYS_REG_WIDTH     = $clog2(NUM_PHYS_REGS);
  localparam int CHECKPOINT_COLUMNS = 4;
  localparam int CKPT_COL_WIDTH     = $clog2(CHECKPOINT_COLUMNS);

  // Free list holds every tag not architecturally mapped at reset.
  localparam int FL_DEPTH     = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int LOG_FL_DEPTH = $clog2(FL_DEPTH);

  typedef logic [PHYS_REG_WIDTH-1:0] phys_reg_tag_t;
  typedef logic [CKPT_COL_WIDTH-1:0] checkpoint_column_t;
  // Index plus one wrap bit, so full and empty are distinguishable.
  typedef logic [LOG_FL_DEPTH:0]     fl_ptr_t;

endpackage

// File: rtl/phys_reg_free_list_if.sv
// Interface bundling the free-list ports.
//   dispatch side : deq_req (in), deq_valid/deq_tag (out)
//   commit side   : enq_valid/enq_tag (in)
//   branch side   : ckpt_save_valid/column, ckpt_restore_valid/column (in)
//   status        : free_count, overflow_err (out)
// Handshake: a dequeue happens on a clock edge where deq_req && deq_valid;
// deq_req with deq_valid low is ignored. enq_valid has no ready: an enqueue
// offered while the list is full is dropped and flagged on overflow_err.
// Modport slave is the free list itself; master is whoever drives it.
interface phys_reg_free_list_if;
  import phys_reg_free_list_pkg::*;

  logic               deq_req;
  logic               deq_valid;
  phys_reg_tag_t      deq_tag;
  logic               enq_valid;
  phys_reg_tag_t      enq_tag;
  logic               ckpt_save_valid;
  checkpoint_column_t ckpt_save_column;
  logic               ckpt_restore_valid;
  checkpoint_column_t ckpt_restore_column;
  fl_ptr_t            free_count;
  logic               overflow_err;

  modport master (
    output deq_req, enq_valid, enq_tag,
    output ckpt_save_valid, ckpt_save_column,
    output ckpt_restore_valid, ckpt_restore_column,
    input  deq_valid, deq_tag, free_count, overflow_err
  );

  modport slave (
    input  deq_req, enq_valid, enq_tag,
    input  ckpt_save_valid, ckpt_save_column,
    input  ckpt_restore_valid, ckpt_restore_column,
    output deq_valid, deq_tag, free_count, overflow_err
  );

endinterface

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags for the rename stage.
// Ports:
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset
//   fl   - phys_reg_free_list_if.slave (dispatch dequeue, commit enqueue,
//          checkpoint save/restore of the head pointer, free_count,
//          overflow_err)
// At reset the list is full with tags NUM_ARCH_REGS..NUM_PHYS_REGS-1.
// A branch checkpoint stores the head pointer; a mispredict restores it,
// handing back every tag dequeued since in one cycle.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic                  CLK,
  input  logic                  nRST,
  phys_reg_free_list_if.slave   fl
);

  phys_reg_tag_t r_entries [FL_DEPTH];
  fl_ptr_t       r_head;
  fl_ptr_t       r_tail;
  fl_ptr_t       r_slots [CHECKPOINT_COLUMNS];
  logic          r_overflow;

  logic [LOG_FL_DEPTH-1:0] w_head_idx;
  logic [LOG_FL_DEPTH-1:0] w_tail_idx;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_enq_fire;
  logic                    w_deq_fire;
  fl_ptr_t                 w_head_next;

  assign w_head_idx = r_head[LOG_FL_DEPTH-1:0];
  assign w_tail_idx = r_tail[LOG_FL_DEPTH-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_head_idx == w_tail_idx) &&
                      (r_head[LOG_FL_DEPTH] != r_tail[LOG_FL_DEPTH]);

  assign w_enq_fire = fl.enq_valid && !w_full;
  // A restoring mispredict squashes the same-cycle dispatch.
  assign w_deq_fire = fl.deq_req && !w_empty && !fl.ckpt_restore_valid;

  always_comb begin
    w_head_next = r_head;
    if (fl.ckpt_restore_valid) begin
      w_head_next = r_slots[fl.ckpt_restore_column];
    end else if (w_deq_fire) begin
      w_head_next = r_head + fl_ptr_t'(1);
    end
  end

  // No enqueue-to-dequeue bypass: outputs come only from registered state.
  assign fl.deq_valid    = !w_empty;
  assign fl.deq_tag      = r_entries[w_head_idx];
  assign fl.free_count   = r_tail - r_head;
  assign fl.overflow_err = r_overflow;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        r_entries[i] <= phys_reg_tag_t'(NUM_ARCH_REGS + i);
      end
    end else if (w_enq_fire) begin
      r_entries[w_tail_idx] <= fl.enq_tag;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_head     <= '0;
      r_tail     <= fl_ptr_t'(FL_DEPTH);
      r_overflow <= 1'b0;
    end else begin
      r_head     <= w_head_next;
      r_overflow <= fl.enq_valid && w_full;
      if (w_enq_fire) begin
        r_tail <= r_tail + fl_ptr_t'(1);
      end
    end
  end

  // The saved head is the pre-dequeue value: a dispatch in the same cycle
  // as the branch is younger than it. A restore in the same cycle wins.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
        r_slots[c] <= '0;
      end
    end else if (fl.ckpt_save_valid && !fl.ckpt_restore_valid) begin
      r_slots[fl.ckpt_save_column] <= r_head;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed scenarios followed by random
// traffic, all checked against a reference model that tracks the free
// list as a circular buffer addressed by unbounded integer counters.
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  logic CLK;
  logic nRST;
  int   total;
  int   bad;

  phys_reg_free_list_if fl ();

  phys_reg_free_list dut (
    .CLK  (CLK),
    .nRST (nRST),
    .fl   (fl)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  int m_mem [FL_DEPTH];
  int m_head;
  int m_tail;
  int m_saved [CHECKPOINT_COLUMNS];
  bit m_ovf;

  task automatic model_reset();
    for (int i = 0; i < FL_DEPTH; i++) m_mem[i] = NUM_ARCH_REGS + i;
    m_head = 0;
    m_tail = FL_DEPTH;
    for (int c = 0; c < CHECKPOINT_COLUMNS; c++) m_saved[c] = 0;
    m_ovf = 1'b0;
  endtask

  // Apply the currently driven inputs to the model, as the edge will.
  task automatic model_edge();
    int  free_now;
    int  old_head;
    free_now = m_tail - m_head;
    old_head = m_head;
    m_ovf = fl.enq_valid && (free_now == FL_DEPTH);
    if (fl.enq_valid && free_now < FL_DEPTH) begin
      m_mem[m_tail % FL_DEPTH] = int'(fl.enq_tag);
      m_tail++;
    end
    if (fl.ckpt_restore_valid) m_head = m_saved[fl.ckpt_restore_column];
    else if (fl.deq_req && free_now > 0) m_head++;
    if (fl.ckpt_save_valid && !fl.ckpt_restore_valid)
      m_saved[fl.ckpt_save_column] = old_head;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int exp_free;
    exp_free = m_tail - m_head;
    chk({tag, ".free_count"}, 32'(fl.free_count), exp_free);
    chk({tag, ".deq_valid"}, 32'(fl.deq_valid), 32'(exp_free != 0));
    chk({tag, ".overflow_err"}, 32'(fl.overflow_err), 32'(m_ovf));
    if (exp_free != 0)
      chk({tag, ".deq_tag"}, 32'(fl.deq_tag), m_mem[m_head % FL_DEPTH]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    fl.deq_req             = 1'b0;
    fl.enq_valid           = 1'b0;
    fl.enq_tag             = '0;
    fl.ckpt_save_valid     = 1'b0;
    fl.ckpt_save_column    = '0;
    fl.ckpt_restore_valid  = 1'b0;
    fl.ckpt_restore_column = '0;
  endtask

  // Called #1 after a rising edge: inputs are already driven.
  task automatic step(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
    idle_inputs();
  endtask

  // Asynchronous reset taken between edges, checked before any clock edge.
  task automatic do_reset(input string tag);
    idle_inputs();
    nRST = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    check_all({tag, "_released"});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    nRST = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    chk("reset_deq_tag", 32'(fl.deq_tag), 32);
    chk("reset_free", 32'(fl.free_count), 32);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Drain the full list: tags 32..63 in order.
    for (int i = 0; i < FL_DEPTH; i++) begin
      chk("drain_tag", 32'(fl.deq_tag), 32'(NUM_ARCH_REGS + i));
      fl.deq_req = 1'b1;
      step("drain");
    end
    chk("drained_valid", 32'(fl.deq_valid), 0);
    chk("drained_free", 32'(fl.free_count), 0);

    // Enqueue into empty with same-cycle deq_req: no bypass.
    fl.enq_valid = 1'b1;
    fl.enq_tag   = 6'd5;
    fl.deq_req   = 1'b1;
    step("enq_empty");
    chk("enq_empty_tag", 32'(fl.deq_tag), 5);
    chk("enq_empty_free", 32'(fl.free_count), 1);

    // Save slot 2 at head 0 (with a same-cycle dequeue), 3 deqs, restore.
    do_reset("rst_ckpt");
    fl.ckpt_save_valid  = 1'b1;
    fl.ckpt_save_column = 2'd2;
    fl.deq_req          = 1'b1;
    step("save_deq0");
    fl.deq_req = 1'b1;
    step("deq1");
    fl.deq_req = 1'b1;
    step("deq2");
    chk("after3_tag", 32'(fl.deq_tag), 35);
    fl.ckpt_restore_valid  = 1'b1;
    fl.ckpt_restore_column = 2'd2;
    step("restore2");
    chk("restore_tag", 32'(fl.deq_tag), 32);
    chk("restore_free", 32'(fl.free_count), 32);

    // Same-cycle restore + deq_req + enqueue.
    do_reset("rst_combo");
    for (int i = 0; i < 4; i++) begin
      fl.deq_req = 1'b1;
      if (i == 2) begin
        fl.ckpt_save_valid  = 1'b1;
        fl.ckpt_save_column = 2'd1;
      end
      step("combo_deq");
    end
    fl.ckpt_restore_valid  = 1'b1;
    fl.ckpt_restore_column = 2'd1;
    fl.deq_req             = 1'b1;
    fl.enq_valid           = 1'b1;
    fl.enq_tag             = 6'd7;
    step("combo_restore");
    chk("combo_tag", 32'(fl.deq_tag), 34);
    chk("combo_free", 32'(fl.free_count), 31);
    for (int i = 0; i < 30; i++) begin
      fl.deq_req = 1'b1;
      step("combo_drain");
    end
    chk("combo_tail_tag", 32'(fl.deq_tag), 7);

    // Overflow on a full list.
    do_reset("rst_ovf");
    fl.enq_valid = 1'b1;
    fl.enq_tag   = 6'd9;
    step("ovf_enq");
    chk("ovf_pulse", 32'(fl.overflow_err), 1);
    chk("ovf_free", 32'(fl.free_count), 32);
    step("ovf_clear");
    chk("ovf_clear", 32'(fl.overflow_err), 0);

    // 40 interleaved enq/deq pairs across the index wrap.
    fl.deq_req = 1'b1;
    step("wrap_prime");
    for (int i = 0; i < 40; i++) begin
      fl.enq_valid = 1'b1;
      fl.enq_tag   = phys_reg_tag_t'($urandom_range(0, NUM_PHYS_REGS - 1));
      fl.deq_req   = 1'b1;
      step("wrap_pair");
    end

    // Random traffic with phases biased toward filling and draining.
    for (int i = 0; i < 600; i++) begin
      bit fill_phase;
      int tail_next;
      int rc;
      fill_phase   = ((i / 60) % 2) == 0;
      fl.enq_valid = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      fl.enq_tag   = phys_reg_tag_t'($urandom_range(0, NUM_PHYS_REGS - 1));
      fl.deq_req   = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fl.ckpt_save_valid  = ($urandom_range(0, 5) == 0);
      fl.ckpt_save_column = checkpoint_column_t'($urandom_range(0, CHECKPOINT_COLUMNS - 1));
      rc        = $urandom_range(0, CHECKPOINT_COLUMNS - 1);
      tail_next = m_tail + ((fl.enq_valid && (m_tail - m_head) < FL_DEPTH) ? 1 : 0);
      // Only restore checkpoints whose reclaimed tags are still intact.
      if ($urandom_range(0, 7) == 0 && m_saved[rc] <= m_head &&
          (tail_next - m_saved[rc]) <= FL_DEPTH) begin
        fl.ckpt_restore_valid  = 1'b1;
        fl.ckpt_restore_column = checkpoint_column_t'(rc);
      end
      step("rand");
      if (i == 400) do_reset("rst_mid");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Circular FIFO of free physical register tags for the OoO MIPS core's rename stage. Supplies destination physical tags to dispatch, reclaims stale tags from the ROB at commit, and snapshots its head pointer into one of CHECKPOINT_COLUMNS slots so a branch mispredict can return speculatively allocated tags in one cycle. Sits between ROB commit (upstream producer of freed tags) and the phys reg map table / dispatch (downstream consumer).

## Interface
- NUM_PHYS_REGS, 64, total physical registers (core_types_pkg)
- NUM_ARCH_REGS, 32, architectural registers; initially mapped 1:1 to phys 0..31
- FL_DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGS = 32, FIFO entries (max simultaneously free tags)
- CHECKPOINT_COLUMNS, 4, checkpoint slots (core_types_pkg)

- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- deq_req  in  1  dispatch consumes deq_tag this cycle
- deq_valid  out  1  list non-empty; deq_tag valid
- deq_tag  out  PHYS_REG_WIDTH (6)  tag at head
- enq_valid  in  1  commit frees a tag
- enq_tag  in  6  freed phys tag
- ckpt_save_valid  in  1  snapshot head pointer
- ckpt_save_column  in  checkpoint_column_t (2)  slot to write
- ckpt_restore_valid  in  1  mispredict: restore head pointer
- ckpt_restore_column  in  2  slot to read
- free_count  out  6  number of free tags, 0..32
- overflow_err  out  1  registered pulse: enqueue dropped because list full

## Operation
- Storage: FL_DEPTH x phys_reg_tag_t. head/tail are $clog2(FL_DEPTH)+1 = 6 bits (index + wrap bit); full when index equal and wrap differs, empty when equal.
- Reset: entry[i] = 32+i, head = 6'b000000, tail = 6'b100000 (full), free_count = 32, deq_valid = 1, deq_tag = 32, overflow_err = 0, all checkpoint slots = 0.
- Dequeue: deq_req && deq_valid -> head += 1. deq_req while empty is ignored (no pointer change).
- Enqueue: enq_valid && !full -> entry[tail index] = enq_tag, tail += 1. enq_valid while full -> dropped, overflow_err = 1 next cycle.
- Save: ckpt_save_valid -> slot[column] = head value before this cycle's dequeue (a same-cycle dequeue is younger than the checkpointing branch).
- Restore: ckpt_restore_valid -> head = slot[column]; a same-cycle deq_req is ignored; a same-cycle enqueue still applies (commits are older than any mispredicted branch). Restore beats save on same cycle.
- Restore never loses tags: entries in [slot, old head) are unmodified because live free count plus reclaimed entries never exceeds FL_DEPTH.
- free_count = tail - head (6-bit modular); after restore reflects restored head.
- Pointer wrap: 31 -> 0 index with wrap bit toggle; arithmetic is natural 6-bit overflow.

## Timing
- deq_valid/deq_tag combinational from registered head and storage; 0-cycle read, pointer advances at next edge.
- Enqueued tag visible at deq_tag no earlier than next cycle; no enqueue-to-dequeue bypass when empty (deq_valid stays 0 that cycle).
- Save/restore take effect at the edge; restored head drives deq_tag next cycle.
- nRST assertion mid-operation returns all state to reset values immediately, independent of CLK.

## Structure
- Add to core_types_pkg: FL_DEPTH, LOG_FL_DEPTH, typedef fl_ptr_t (LOG_FL_DEPTH+1 bits). phys_reg_tag_t and checkpoint_column_t already there.
- Single module; no sub-module. Checkpoint slots are a small fl_ptr_t array inside.

## Test plan
- Reset -> deq_valid=1, deq_tag=32, free_count=32; 32 consecutive deq_req -> tags 32..63, then deq_valid=0, free_count=0.
- From empty: enq_valid with tag 5, same-cycle deq_req -> no dequeue; next cycle deq_tag=5, free_count=1.
- Save slot 2 at head=0, dequeue 3 tags (32,33,34), restore slot 2 -> next cycle deq_tag=32, free_count=32.
- Same-cycle restore + deq_req + enq: after 4 deqs and save at head=2, restore slot with enq tag 7 -> head=2, tail advanced, 7 appended.
- Full list + enq_valid tag 9 -> dropped, overflow_err=1 for one cycle, free_count stays 32.
- Wrap: 40 interleaved enq/deq pairs -> FIFO order preserved across index wrap; nRST mid-sequence -> reset values immediately.
